// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, flag positions
// and elaboration helpers for the prefix adder pipeline.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_ADC = 2'b10,
    ALU_SBB = 2'b11
  } alu_op_e;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_CF = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Step after which rank r sits; steps are prep (0)
  // and prefix levels 1..levels.
  function automatic int rank_step(
    input int r,
    input int levels,
    input int stages
  );
    return ((r + 1) * (levels + 1)) / stages - 1;
  endfunction

  function automatic int step_rank(
    input int s,
    input int levels,
    input int stages
  );
    for (int r = 0; r < stages; r++)
      if (rank_step(r, levels, stages) == s) return r;
    return -1;
  endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone (P,G) combine cell with pass-through for
// bits below the current span.
module prefix_gp_cell (
  input  logic pass,
  input  logic ph,
  input  logic gh,
  input  logic pl,
  input  logic gl,
  output logic p,
  output logic g
);

  assign p = pass ? ph : (ph & pl);
  assign g = pass ? gh : (gh | (ph & gl));

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone add/sub with valid/ready flow
// control, bubble collapse and full condition codes.
module prefix_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int LAST   = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c0;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } gp_t;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] adv;

  always_comb begin
    vin = '0;
    vin[0] = in_valid;
    for (int r = 1; r < STAGES; r++)
      vin[r] = v[r-1];
  end

  always_comb begin
    adv = '0;
    adv[LAST] = !v[LAST] || out_ready;
    for (int r = LAST - 1; r >= 0; r--)
      adv[r] = !v[r] || adv[r+1];
  end

  assign in_ready  = adv[0];
  assign out_valid = v[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int r = 0; r < STAGES; r++)
        if (adv[r]) v[r] <= vin[r];
    end
  end

  logic [WIDTH-1:0] bx;
  logic             cin0;
  logic             sub;

  always_comb begin
    bx   = in_b;
    cin0 = 1'b0;
    sub  = 1'b0;
    unique case (1'b1)
      (in_op == ALU_ADD): begin
        bx   = in_b;
        cin0 = 1'b0;
      end
      (in_op == ALU_SUB): begin
        bx   = ~in_b;
        cin0 = 1'b1;
        sub  = 1'b1;
      end
      (in_op == ALU_ADC): begin
        bx   = in_b;
        cin0 = in_cin;
      end
      (in_op == ALU_SBB): begin
        bx   = ~in_b;
        cin0 = ~in_cin;
        sub  = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar s = 0; s <= LEVELS; s++) begin : lv
    gp_t o;
    if (s == 0) begin : g_prep
      logic [WIDTH-1:0] hp;
      logic [WIDTH-1:0] gc;
      assign hp = in_a ^ bx;
      // carry-in folded in as generate of bit -1
      assign gc = (in_a & bx)
                | {{(WIDTH-1){1'b0}}, hp[0] & cin0};
      assign o = '{h: hp, p: hp, g: gc,
                   c0: cin0, sub: sub, tag: in_tag};
    end else begin : g_lvl
      localparam int SPAN = 1 << (s - 1);
      localparam int RP =
        step_rank(s - 1, LEVELS, STAGES);
      gp_t d;
      logic [WIDTH-1:0] pn;
      logic [WIDTH-1:0] gn;
      if (RP >= 0) begin : g_reg
        gp_t q;
        always_ff @(posedge clk)
          if (adv[RP] && vin[RP]) q <= lv[s-1].o;
        assign d = q;
      end else begin : g_wire
        assign d = lv[s-1].o;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int LO = (i >= SPAN) ? i - SPAN : 0;
        prefix_gp_cell u_cell (
          .pass (i < SPAN),
          .ph   (d.p[i]),
          .gh   (d.g[i]),
          .pl   (d.p[LO]),
          .gl   (d.g[LO]),
          .p    (pn[i]),
          .g    (gn[i])
        );
      end
      assign o = '{h: d.h, p: pn, g: gn,
                   c0: d.c0, sub: d.sub, tag: d.tag};
    end
  end

  gp_t              f;
  logic [WIDTH-1:0] sum;
  logic [3:0]       flags;
  logic             cout;
  logic             unused;

  assign f      = lv[LEVELS].o;
  assign sum    = f.h ^ {f.g[WIDTH-2:0], f.c0};
  assign cout   = f.g[WIDTH-1];
  assign unused = ^f.p;

  always_comb begin
    flags = '0;
    flags[FLAG_CF] = cout ^ f.sub;
    flags[FLAG_OF] = f.g[WIDTH-2] ^ cout;
    flags[FLAG_SF] = sum[WIDTH-1];
    flags[FLAG_ZF] = (sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else if (adv[LAST] && vin[LAST]) begin
      out_sum   <= sum;
      out_flags <= flags;
      out_tag   <= f.tag;
    end
  end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Scoreboard bench for prefix_addsub_pipe against an
// arithmetic reference model.
module tb_prefix_addsub_pipe;

  localparam int W  = 64;
  localparam int S  = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic [3:0]    out_flags;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [3:0]    flags;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int checks = 0;
  int fails = 0;
  int popped = 0;
  int rdy_mode = 0;
  int pc = 0;

  always #5 clk = ~clk;

  prefix_addsub_pipe #(
    .WIDTH(W), .STAGES(S), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags),
    .out_tag(out_tag)
  );

  task automatic chk(
    input string nm,
    input logic [W-1:0] act,
    input logic [W-1:0] req
  );
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, req);
    end
  endtask

  // Exact integer arithmetic in W+2 bits.
  function automatic exp_t model(
    input logic [1:0]    op,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b,
    input logic          cin,
    input logic [TW-1:0] tag
  );
    exp_t e;
    logic [W+1:0] ua, ub, uk, ur;
    logic signed [W+1:0] sa, sb, sk, sr;
    logic is_sub;
    is_sub = (op == 2'b01) || (op == 2'b11);
    ua = {2'b00, a};
    ub = {2'b00, b};
    uk = {{(W+1){1'b0}}, (op == 2'b10 || op == 2'b11) & cin};
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    sk = uk;
    ur = is_sub ? ua - ub - uk : ua + ub + uk;
    sr = is_sub ? sa - sb - sk : sa + sb + sk;
    e.sum = ur[W-1:0];
    e.tag = tag;
    e.flags[3] = is_sub ? ur[W+1] : ur[W];
    e.flags[2] = !(sr[W+1] == sr[W] && sr[W] == sr[W-1]);
    e.flags[1] = ur[W-1];
    e.flags[0] = (ur[W-1:0] == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] x;
    case ($urandom_range(7))
      0: x = '0;
      1: x = '1;
      2: x = {1'b1, {(W-1){1'b0}}};
      3: x = {1'b0, {(W-1){1'b1}}};
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      2: out_ready = (pc % 4 == 0) || (pc % 4 == 3);
      default: out_ready = 1'($urandom_range(1));
    endcase
    pc++;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious: out_valid=1 tag %0h, required 0",
                 out_tag);
      end else begin
        cur = q[0];
        chk("sum", out_sum, cur.sum);
        chk("flags", W'(out_flags), W'(cur.flags));
        chk("tag", W'(out_tag), W'(cur.tag));
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic send(
    input logic [1:0]    op,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b,
    input logic          cin,
    input logic [TW-1:0] tag,
    input exp_t          e
  );
    bit ok;
    int n;
    ok = 0;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_tag = tag;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic rsend(input logic [TW-1:0] tag);
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic cin;
    op = 2'($urandom_range(3));
    a = rnd();
    b = rnd();
    cin = 1'($urandom_range(1));
    send(op, a, b, cin, tag, model(op, a, b, cin, tag));
  endtask

  task automatic lat_check();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk("latency", W'(n), W'(S));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", W'(q.size()), '0);
  endtask

  task automatic fill(output int n);
    bit full;
    full = 0;
    n = 0;
    in_valid = 1'b1;
    while (!full && n < 20) begin
      in_op = 2'($urandom_range(3));
      in_a = rnd();
      in_b = rnd();
      in_cin = 1'($urandom_range(1));
      in_tag = TW'(n);
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
        n++;
      end else begin
        full = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones, mn, mx;
    int n, p0;
    ones = '1;
    mn = {1'b1, {(W-1){1'b0}}};
    mx = {1'b0, {(W-1){1'b1}}};
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_flags", W'(out_flags), '0);
    chk("rst_out_tag", W'(out_tag), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    send(2'b00, mx, W'(1), 1'b0, 4'd1,
         exp_t'{sum: mn, flags: 4'b0110, tag: 4'd1});
    lat_check();
    drain();
    send(2'b01, W'(5), W'(5), 1'b0, 4'd2,
         exp_t'{sum: '0, flags: 4'b0001, tag: 4'd2});
    lat_check();
    drain();
    send(2'b01, '0, W'(1), 1'b0, 4'd3,
         exp_t'{sum: ones, flags: 4'b1010, tag: 4'd3});
    lat_check();
    drain();
    send(2'b10, ones, '0, 1'b1, 4'd4,
         exp_t'{sum: '0, flags: 4'b1001, tag: 4'd4});
    lat_check();
    drain();
    send(2'b11, '0, '0, 1'b1, 4'd5,
         exp_t'{sum: ones, flags: 4'b1010, tag: 4'd5});
    lat_check();
    drain();
    send(2'b01, mn, W'(1), 1'b0, 4'd6,
         exp_t'{sum: mx, flags: 4'b0100, tag: 4'd6});
    lat_check();
    drain();

    rdy_mode = 2;
    p0 = popped;
    for (int t = 0; t < 8; t++) rsend(TW'(t));
    drain();
    chk("tag_stream_count", W'(popped - p0), W'(8));
    rdy_mode = 0;

    rdy_mode = 1;
    fill(n);
    chk("full_depth", W'(n), W'(S));
    rdy_mode = 0;
    drain();

    rsend(4'd9);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    fill(n);
    chk("bubble_depth", W'(n), W'(S - 1));
    rdy_mode = 0;
    drain();

    rdy_mode = 1;
    fill(n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_out_sum", out_sum, '0);
    chk("arst_out_flags", W'(out_flags), '0);
    chk("arst_out_tag", W'(out_tag), '0);
    q.delete();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_rst_idle", W'(out_valid), '0);
    @(posedge clk);
    #1;
    rsend(4'd7);
    lat_check();
    drain();

    rdy_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      rsend(TW'(i));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/prefix_addsub_pipe.md
Name: prefix_addsub_pipe

Overview:
Parametrised, pipelined Kogge-Stone prefix adder/subtractor for the execute stage of the Y86 ALU. It is the next generation of the fixed 64-bit combinational prefix adder. New features: width parameter, selectable register stages across the log2(WIDTH) prefix levels, four arithmetic ops, valid/ready flow control with bubble collapse, and full condition-code output (ZF/SF/OF/CF).

Parameters:
WIDTH, 64, operand/result width; power of two, 8..128
STAGES, 2, pipeline register ranks; 1..LEVELS+1 where LEVELS = log2(WIDTH); ranks evenly spaced across prefix levels, last rank always at output
TAG_W, 4, width of opaque tag carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
in_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry/borrow-in, used by ADC/SBB only
in_tag  in  TAG_W  passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result
out_flags  out  4  {CF, OF, SF, ZF}
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync release): every stage valid bit = 0, so out_valid = 0. out_sum, out_flags and out_tag = 0. in_ready = 1 from the first cycle after release.
- Operand prep at input:
  - ADD: B' = b, c0 = 0
  - SUB: B' = ~b, c0 = 1
  - ADC: B' = b, c0 = in_cin
  - SBB: B' = ~b, c0 = ~in_cin (in_cin = 1 means borrow-in)
- c0 is injected as generate of bit -1, so all prefix carries include it.
- Level 0: p_i = a_i ^ B'_i, g_i = a_i & B'_i. Levels k = 1..LEVELS use span 2^(k-1).
  - Bits i < 2^(k-1) pass through unchanged.
  - All other bits combine with bit i - 2^(k-1).
- sum_0 = p_0 ^ c0; sum_i = p_i ^ G_(i-1).
- Flags:
  - carry_out = G_(WIDTH-1).
  - CF = carry_out for ADD/ADC; CF = ~carry_out (borrow) for SUB/SBB.
  - OF = carry into MSB ^ carry_out.
  - SF = sum[WIDTH-1]; ZF = (sum == 0).
- Latency: exactly STAGES cycles from the in_valid&&in_ready edge to out_valid, with no stall. Throughput is 1 op/cycle.
- Flow control, per rank r:
  - advance_r = !valid_r || advance_(r+1); advance_last = !out_valid || out_ready.
  - in_ready = advance_0, combinational from out_ready through the chain; no storage beyond the ranks.
  - Bubbles collapse: an empty rank accepts even when downstream is stalled.
- Stall: while out_valid && !out_ready, out_sum, out_flags and out_tag hold stable. A rank that does not advance holds its payload.
- Simultaneous accept at input and drain at output in one cycle: both occur and occupancy is unchanged.
- Ordering is strictly FIFO. The tag travels in lockstep with its data.
- Overflow and wrap: the sum is modulo 2^WIDTH and is never saturated.
- Reset mid-operation: all in-flight ops are discarded and no result is emitted. in_valid sampled during reset is ignored.
- Payload registers need no reset beyond the output rank; valid bits must be reset.
- X on payload while valid = 0 must not propagate to out_valid.

Decomposition:
- Package alu_pkg:
  - op encodings ALU_ADD/SUB/ADC/SBB
  - flag bit indices FLAG_ZF=0, SF=1, OF=2, CF=3
  - function clog2 for LEVELS and rank placement
- Sub-module prefix_gp_cell: (P,G) = (Ph&Pl, Gh | Ph&Gl), with a pass-through mode for bits below the span. It is generated per bit per level.
- Rank insertion: a generate loop inside prefix_addsub_pipe.

Test Plan:
- ADD, WIDTH=64, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> after STAGES cycles: sum=64'h8000_0000_0000_0000, OF=1, SF=1, ZF=0, CF=0.
- SUB a=5, b=5 -> sum=0, ZF=1, CF=0, OF=0. SUB a=0, b=1 -> sum=all ones, CF=1 (borrow), SF=1.
- ADC a=all ones, b=0, cin=1 -> sum=0, CF=1, ZF=1. SBB a=0, b=0, cin=1 -> sum=all ones, CF=1.
- Backpressure: stream 8 ops with tags 0..7 while out_ready toggles 1,0,0,1… -> results emerge in tag order, payload stable during stalls, none lost or duplicated. With out_ready=0, in_ready drops after STAGES accepts.
- Bubble collapse: STAGES=3, one op accepted, then idle, then out_ready held 0 -> 2 more ops still accepted. in_ready deasserts only when all ranks are full.
- Async reset asserted with 3 ops in flight, mid-cycle -> out_valid=0 immediately, outputs 0. After release, the first new op returns with latency STAGES. Repeat with WIDTH=8, STAGES=4 against a random reference model for 10k ops.
